// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard issue controller: opcodes, instruction
// field positions, FSM state encoding and the source/destination decoder.
package hazard_pkg;

  localparam int unsigned INSTR_W  = 20;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned CNT_W    = 3;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 19;
  localparam int unsigned OPC_LSB = 16;
  localparam int unsigned FA_MSB  = 15;
  localparam int unsigned FA_LSB  = 12;
  localparam int unsigned FB_MSB  = 11;
  localparam int unsigned FB_LSB  = 8;
  localparam int unsigned FC_MSB  = 7;
  localparam int unsigned FC_LSB  = 4;

  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_NOP   = 4'b0000;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              wr;
    logic [REG_AW-1:0] dst;
  } decode_t;

  // Stores read fields A/B and write nothing; NOPs touch nothing;
  // everything else reads B/C and writes A.
  function automatic decode_t decode(input logic [INSTR_W-1:0] instr);
    decode_t d;
    logic [3:0] opc;
    opc    = instr[OPC_MSB:OPC_LSB];
    d      = '0;
    d.dst  = instr[FA_MSB:FA_LSB];
    if (opc == OP_STORE) begin
      d.use1 = 1'b1;
      d.use2 = 1'b1;
      d.src1 = instr[FA_MSB:FA_LSB];
      d.src2 = instr[FB_MSB:FB_LSB];
    end else if (opc != OP_NOP) begin
      d.use1 = 1'b1;
      d.use2 = 1'b1;
      d.src1 = instr[FB_MSB:FB_LSB];
      d.src2 = instr[FC_MSB:FC_LSB];
      d.wr   = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-back countdown scoreboard (16 x 3-bit counters).
// Ports: clk/rst_n; i_load_en/i_load_addr load WB_LATENCY into one counter;
// i_query_addr1/2 -> o_busy1_c/o_busy2_c combinational busy flags.
// Macro FORWARDING_EN: a counter of 1 is reported as not busy (bypass).
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned WB_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_en,
  input  logic [REG_AW-1:0] i_load_addr,
  input  logic [REG_AW-1:0] i_query_addr1,
  input  logic [REG_AW-1:0] i_query_addr2,
  output logic              o_busy1_c,
  output logic              o_busy2_c
);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_cnt1;
  logic [CNT_W-1:0] w_cnt2;

  // Load wins over the free-running decrement on the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (i_load_en && (i_load_addr == REG_AW'(i)))
          r_cnt[i] <= CNT_W'(WB_LATENCY);
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  assign w_cnt1 = r_cnt[i_query_addr1];
  assign w_cnt2 = r_cnt[i_query_addr2];

`ifdef FORWARDING_EN
  assign o_busy1_c = (w_cnt1 > CNT_W'(1));
  assign o_busy2_c = (w_cnt2 > CNT_W'(1));
`else
  assign o_busy1_c = (w_cnt1 != '0);
  assign o_busy2_c = (w_cnt2 != '0);
`endif

endmodule

// File: rtl/hazard_issue_controller.sv
// Single-entry issue buffer that holds an instruction until its source
// registers are free of pending write-backs, then issues it downstream.
// Ports: clock/reset (async active-low); instruction/inValid/inReady input
// handshake; flush drops the held entry; issueValid/issueReady/issueInstruction
// output handshake; ReadAddressRF1/2 source addresses of the held entry;
// stall and saturating stallCount (hazard cycles).
// Macro FORWARDING_EN (in reg_scoreboard): one-cycle-early source availability.
module hazard_issue_controller
  import hazard_pkg::*;
#(
  parameter int unsigned WB_LATENCY  = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_W-1:0]     instruction,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   flush,
  input  logic                   issueReady,
  output logic                   issueValid,
  output logic [INSTR_W-1:0]     issueInstruction,
  output logic [REG_AW-1:0]      ReadAddressRF1,
  output logic [REG_AW-1:0]      ReadAddressRF2,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam logic [0:0] S_EMPTY = EMPTY;
  localparam logic [0:0] S_HOLD  = HOLD;

  logic [0:0]             r_state;
  logic [INSTR_W-1:0]     r_hold;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic [0:0]             w_state_nxt;
  logic [INSTR_W-1:0]     w_hold_nxt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;

  decode_t w_dec;
  logic    w_hold_st;
  logic    w_busy1;
  logic    w_busy2;
  logic    w_hazard;
  logic    w_fire;
  logic    w_accept;

  // Decode and hazard detection on the held entry
  assign w_dec     = decode(r_hold);
  assign w_hold_st = (r_state == S_HOLD);
  assign w_hazard  = w_hold_st && ((w_dec.use1 && w_busy1) || (w_dec.use2 && w_busy2));

  reg_scoreboard #(
    .WB_LATENCY (WB_LATENCY)
  ) u_scoreboard (
    .clk           (clock),
    .rst_n         (reset),
    .i_load_en     (w_fire && w_dec.wr),
    .i_load_addr   (w_dec.dst),
    .i_query_addr1 (w_dec.src1),
    .i_query_addr2 (w_dec.src2),
    .o_busy1_c     (w_busy1),
    .o_busy2_c     (w_busy2)
  );

  // Handshakes; a held entry that issues frees the slot in the same cycle
  assign issueValid       = w_hold_st && !w_hazard;
  assign w_fire           = issueValid && issueReady;
  assign inReady          = !flush && (!w_hold_st || w_fire);
  assign w_accept         = inValid && inReady;
  assign stall            = w_hold_st && !w_fire;
  assign issueInstruction = w_hold_st ? r_hold : '0;
  assign ReadAddressRF1   = (w_hold_st && w_dec.use1) ? w_dec.src1 : '0;
  assign ReadAddressRF2   = (w_hold_st && w_dec.use2) ? w_dec.src2 : '0;
  assign stallCount       = r_stall_cnt;

  // State, holding register and stall counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_hold      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // Next state: flush dominates, then refill, then drain
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_hazard && (r_stall_cnt != '1))
      w_stall_cnt_nxt = r_stall_cnt + STALL_CNT_W'(1);
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_hold_nxt  = '0;
    end else if (w_accept) begin
      w_state_nxt = S_HOLD;
      w_hold_nxt  = instruction;
    end else if (w_fire) begin
      w_state_nxt = S_EMPTY;
      w_hold_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_hazard_issue_controller.sv
module tb_hazard_issue_controller;

  localparam int unsigned NROWS = 18;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [19:0] instruction;
  logic        inValid;
  logic        inReady;
  logic        flush;
  logic        issueReady;
  logic        issueValid;
  logic [19:0] issueInstruction;
  logic [3:0]  ReadAddressRF1;
  logic [3:0]  ReadAddressRF2;
  logic        stall;
  logic [15:0] stallCount;

  int checks   = 0;
  int failures = 0;

  hazard_issue_controller #(
    .WB_LATENCY  (3),
    .STALL_CNT_W (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .instruction      (instruction),
    .inValid          (inValid),
    .inReady          (inReady),
    .flush            (flush),
    .issueReady       (issueReady),
    .issueValid       (issueValid),
    .issueInstruction (issueInstruction),
    .ReadAddressRF1   (ReadAddressRF1),
    .ReadAddressRF2   (ReadAddressRF2),
    .stall            (stall),
    .stallCount       (stallCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        in_valid;
    logic [19:0] instr;
    logic        fl;
    logic        ir;
    logic        e_rdy;
    logic        e_vld;
    logic        e_stall;
    logic [19:0] e_ii;
    logic [3:0]  e_rf1;
    logic [3:0]  e_rf2;
    logic [15:0] e_sc;
  } vec_t;

  vec_t tbl [NROWS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rdy, input logic e_vld,
                         input logic e_stall, input logic [19:0] e_ii,
                         input logic [3:0] e_rf1, input logic [3:0] e_rf2,
                         input logic [15:0] e_sc);
    chk({tag, ".inReady"},    32'(inReady),          32'(e_rdy));
    chk({tag, ".issueValid"}, 32'(issueValid),       32'(e_vld));
    chk({tag, ".stall"},      32'(stall),            32'(e_stall));
    chk({tag, ".issueInstr"}, 32'(issueInstruction), 32'(e_ii));
    chk({tag, ".rf1"},        32'(ReadAddressRF1),   32'(e_rf1));
    chk({tag, ".rf2"},        32'(ReadAddressRF2),   32'(e_rf2));
    chk({tag, ".stallCount"}, 32'(stallCount),       32'(e_sc));
  endtask

  task automatic apply(input logic iv, input logic [19:0] ins, input logic fl, input logic ir);
    @(negedge clock);
    inValid     = iv;
    instruction = ins;
    flush       = fl;
    issueReady  = ir;
    #1;
  endtask

  task automatic set_row(input int idx, input logic iv, input logic [19:0] ins,
                         input logic fl, input logic ir, input logic e_rdy,
                         input logic e_vld, input logic e_stall, input logic [19:0] e_ii,
                         input logic [3:0] e_rf1, input logic [3:0] e_rf2,
                         input logic [15:0] e_sc);
    tbl[idx].in_valid = iv;   tbl[idx].instr   = ins;     tbl[idx].fl   = fl;
    tbl[idx].ir       = ir;   tbl[idx].e_rdy   = e_rdy;   tbl[idx].e_vld = e_vld;
    tbl[idx].e_stall  = e_stall; tbl[idx].e_ii = e_ii;    tbl[idx].e_rf1 = e_rf1;
    tbl[idx].e_rf2    = e_rf2; tbl[idx].e_sc   = e_sc;
  endtask

  logic [15:0] sc_t;
  logic [15:0] sc_b;

  initial begin
    // Stall cycles for the RAW pair: 3 without bypass, 2 with bypass
    sc_t = FWD ? 16'd2 : 16'd3;

    // Idle, independent back-to-back pair, drain, RAW pair, store, reader of r1/rF
    set_row(0,  0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, 16'd0);
    set_row(1,  1, 20'h10120, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, 16'd0);
    set_row(2,  1, 20'h13450, 0, 1, 1, 1, 0, 20'h10120, 4'h1, 4'h2, 16'd0);
    set_row(3,  0, 20'h00000, 0, 1, 1, 1, 0, 20'h13450, 4'h4, 4'h5, 16'd0);
    set_row(4,  0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, 16'd0);
    set_row(5,  0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, 16'd0);
    set_row(6,  1, 20'h11230, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, 16'd0);
    set_row(7,  1, 20'h12100, 0, 1, 1, 1, 0, 20'h11230, 4'h2, 4'h3, 16'd0);
    set_row(8,  0, 20'h00000, 0, 1, 0, 0, 1, 20'h12100, 4'h1, 4'h0, 16'd0);
    set_row(9,  0, 20'h00000, 0, 1, 0, 0, 1, 20'h12100, 4'h1, 4'h0, 16'd1);
    if (FWD) begin
      set_row(10, 0, 20'h00000, 0, 1, 1, 1, 0, 20'h12100, 4'h1, 4'h0, 16'd2);
      set_row(11, 0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, 16'd2);
    end else begin
      set_row(10, 0, 20'h00000, 0, 1, 0, 0, 1, 20'h12100, 4'h1, 4'h0, 16'd2);
      set_row(11, 0, 20'h00000, 0, 1, 1, 1, 0, 20'h12100, 4'h1, 4'h0, 16'd3);
    end
    set_row(12, 0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, sc_t);
    set_row(13, 0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, sc_t);
    set_row(14, 1, 20'hC1F00, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, sc_t);
    set_row(15, 1, 20'h201F0, 0, 1, 1, 1, 0, 20'hC1F00, 4'h1, 4'hF, sc_t);
    set_row(16, 0, 20'h00000, 0, 1, 1, 1, 0, 20'h201F0, 4'h1, 4'hF, sc_t);
    set_row(17, 0, 20'h00000, 0, 1, 1, 0, 0, 20'h00000, 4'h0, 4'h0, sc_t);

    // Reset held with no input
    reset = 1'b0; inValid = 1'b0; instruction = '0; flush = 1'b0; issueReady = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk_all("reset", 1, 0, 0, 20'h0, 4'h0, 4'h0, 16'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < int'(NROWS); i++) begin
      apply(tbl[i].in_valid, tbl[i].instr, tbl[i].fl, tbl[i].ir);
      chk_all($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_stall,
              tbl[i].e_ii, tbl[i].e_rf1, tbl[i].e_rf2, tbl[i].e_sc);
    end

    // Downstream back-pressure on a hazard-free entry
    apply(1, 20'h34560, 0, 1);
    chk_all("bp_acc", 1, 0, 0, 20'h0, 4'h0, 4'h0, sc_t);
    for (int i = 0; i < 4; i++) begin
      apply(1, 20'h45670, 0, 0);
      chk_all($sformatf("bp%0d", i), 0, 1, 1, 20'h34560, 4'h5, 4'h6, sc_t);
    end
    apply(0, 20'h0, 0, 1);
    chk_all("bp_rel", 1, 1, 0, 20'h34560, 4'h5, 4'h6, sc_t);

    // Flush during a hazard stall; scoreboard keeps counting down
    apply(1, 20'h17000, 0, 1);
    chk_all("fl_acc", 1, 0, 0, 20'h0, 4'h0, 4'h0, sc_t);
    apply(1, 20'h28700, 0, 1);
    chk_all("fl_wr", 1, 1, 0, 20'h17000, 4'h0, 4'h0, sc_t);
    apply(1, 20'h55550, 1, 1);
    chk_all("fl_haz", 0, 0, 1, 20'h28700, 4'h7, 4'h0, sc_t);
    apply(1, 20'h28700, 0, 1);
    chk_all("fl_empty", 1, 0, 0, 20'h0, 4'h0, 4'h0, sc_t + 16'd1);
    apply(0, 20'h0, 0, 1);
    if (FWD) chk_all("fl_cnt1", 1, 1, 0, 20'h28700, 4'h7, 4'h0, sc_t + 16'd1);
    else     chk_all("fl_cnt1", 0, 0, 1, 20'h28700, 4'h7, 4'h0, sc_t + 16'd1);
    apply(0, 20'h0, 0, 1);
    if (FWD) chk_all("fl_done", 1, 0, 0, 20'h0, 4'h0, 4'h0, sc_t + 16'd1);
    else     chk_all("fl_done", 1, 1, 0, 20'h28700, 4'h7, 4'h0, sc_t + 16'd2);
    sc_b = FWD ? sc_t + 16'd1 : sc_t + 16'd2;

    // Asynchronous reset in the middle of a hazard stall
    apply(1, 20'h19000, 0, 1);
    chk_all("rs_acc", 1, 0, 0, 20'h0, 4'h0, 4'h0, sc_b);
    apply(1, 20'h20900, 0, 1);
    chk_all("rs_wr", 1, 1, 0, 20'h19000, 4'h0, 4'h0, sc_b);
    apply(0, 20'h0, 0, 1);
    chk_all("rs_haz", 0, 0, 1, 20'h20900, 4'h9, 4'h0, sc_b);
    #2 reset = 1'b0;
    #1;
    chk_all("rs_async", 1, 0, 0, 20'h0, 4'h0, 4'h0, 16'd0);
    @(negedge clock);
    #1;
    chk_all("rs_held", 1, 0, 0, 20'h0, 4'h0, 4'h0, 16'd0);
    reset = 1'b1;
    apply(1, 20'h20900, 0, 1);
    chk_all("rs_reacc", 1, 0, 0, 20'h0, 4'h0, 4'h0, 16'd0);
    apply(0, 20'h0, 0, 1);
    chk_all("rs_clear", 1, 1, 0, 20'h20900, 4'h9, 4'h0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
